// File: rtl/out_acc_wr_gen.sv
// out_acc_wr_gen: writes one 3x3-window result per pixel and channel pass to the
// output feature-map BRAM. Pass 0 writes directly. Later passes read, add and write
// back. Two forwarding paths cover the BRAM's read-first, 1-cycle read latency.
module out_acc_wr_gen #(
  parameter int BRAM_ADDR_BIT = 32,
  parameter int DATA_BIT      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [11:0]                width,
  input  logic [11:0]                channel,
  input  logic                       in_valid,
  input  logic signed [DATA_BIT-1:0] in_data,
  output logic                       rd_en,
  output logic [BRAM_ADDR_BIT-1:0]   rd_addr,
  input  logic signed [DATA_BIT-1:0] rd_data,
  output logic                       wr_en,
  output logic [BRAM_ADDR_BIT-1:0]   wr_addr,
  output logic signed [DATA_BIT-1:0] wr_data,
  output logic                       done,
  output logic [11:0]                pix_cnt,
  output logic [11:0]                channel_cnt
);

  localparam logic signed [DATA_BIT-1:0] SAT_MAX = {1'b0, {(DATA_BIT-1){1'b1}}};
  localparam logic signed [DATA_BIT-1:0] SAT_MIN = {1'b1, {(DATA_BIT-1){1'b0}}};

  // Output map geometry. OW*OW needs 24 bits even though pix_cnt is only 12 bits wide.
  logic [11:0] ow;
  logic [23:0] ow_sq;
  logic        pix_last;
  logic        chan_last;
  logic        job_last;

  assign ow        = width - 12'd2;
  assign ow_sq     = {12'd0, ow} * {12'd0, ow};
  assign pix_last  = ({12'd0, pix_cnt} == (ow_sq - 24'd1));
  assign chan_last = (channel_cnt == (channel - 12'd1));
  assign job_last  = pix_last && chan_last;

  // Stage B registers: one accepted pixel waiting for its BRAM read data.
  logic                       b_valid;
  logic [BRAM_ADDR_BIT-1:0]   b_addr;
  logic signed [DATA_BIT-1:0] b_data;
  logic                       b_first;
  logic                       b_last;

  // Commit shadow: the write that reached the BRAM at the previous edge. A read-first
  // BRAM read issued in that same cycle returned the old value, so this copy wins.
  logic                       sh_valid;
  logic [BRAM_ADDR_BIT-1:0]   sh_addr;
  logic signed [DATA_BIT-1:0] sh_data;

  logic signed [DATA_BIT-1:0] base;
  logic signed [DATA_BIT:0]   sum_wide;
  logic signed [DATA_BIT-1:0] sum;

  // Pixel and channel counters. They advance on every accepted input and wrap per job.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt     <= '0;
      channel_cnt <= '0;
    end else if (in_valid) begin
      if (pix_last) begin
        pix_cnt     <= '0;
        channel_cnt <= chan_last ? 12'd0 : channel_cnt + 12'd1;
      end else begin
        pix_cnt <= pix_cnt + 12'd1;
      end
    end
  end

  // Stage A: issue the BRAM read for the current pixel's partial sum.
  assign rd_en   = in_valid;
  assign rd_addr = in_valid ? BRAM_ADDR_BIT'(pix_cnt) : '0;

  // Stage A -> B capture of the accepted pixel and its flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_addr  <= '0;
      b_data  <= '0;
      b_first <= 1'b0;
      b_last  <= 1'b0;
    end else begin
      b_valid <= in_valid;
      b_addr  <= BRAM_ADDR_BIT'(pix_cnt);
      b_data  <= in_data;
      b_first <= (channel_cnt == 12'd0);
      b_last  <= job_last;
    end
  end

  // Stage B: pick the newest partial sum for b_addr, then do a saturating add.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    base = '0;
    if (b_first) begin
      base = '0;
    end else if (wr_en && (wr_addr == b_addr)) begin
      base = wr_data;
    end else if (sh_valid && (sh_addr == b_addr)) begin
      base = sh_data;
    end else begin
      base = rd_data;
    end

    sum_wide = {base[DATA_BIT-1], base} + {b_data[DATA_BIT-1], b_data};
    sum      = sum_wide[DATA_BIT-1:0];
    if (sum_wide[DATA_BIT] != sum_wide[DATA_BIT-1]) begin
      sum = sum_wide[DATA_BIT] ? SAT_MIN : SAT_MAX;
    end
  end

  // Stage C: registered BRAM write port and the end-of-job pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en   <= b_valid;
      wr_addr <= b_addr;
      wr_data <= sum;
      done    <= b_valid && b_last;
    end
  end

  // Commit shadow update: remember each write as it lands in the BRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_valid <= 1'b0;
      sh_addr  <= '0;
      sh_data  <= '0;
    end else if (wr_en) begin
      sh_valid <= 1'b1;
      sh_addr  <= wr_addr;
      sh_data  <= wr_data;
    end
  end

endmodule

// File: tb/tb_out_acc_wr_gen.sv
// tb_out_acc_wr_gen: random and directed stimulus for out_acc_wr_gen. The expected
// write stream comes from a per-address accumulator model and is queued at issue
// time. A monitor compares each BRAM write as it appears.
module tb_out_acc_wr_gen;

  localparam int AW = 32;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [11:0]          width;
  logic [11:0]          channel;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;
  logic                 done;
  logic [11:0]          pix_cnt;
  logic [11:0]          channel_cnt;

  out_acc_wr_gen #(.BRAM_ADDR_BIT(AW), .DATA_BIT(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .width      (width),
    .channel    (channel),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done),
    .pix_cnt    (pix_cnt),
    .channel_cnt(channel_cnt)
  );

  always #5 clk = ~clk;

  // Read-first simple dual-port BRAM. Reset fills it with garbage so that any stray
  // use of rd_data on a first pass is visible.
  logic signed [DW-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'($urandom);
      rd_data <= '0;
    end else begin
      if (rd_en) rd_data <= mem[rd_addr[11:0]];
      if (wr_en) mem[wr_addr[11:0]] <= wr_data;
    end
  end

  typedef struct {
    int addr;
    int data;
    int last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  // Reference model state: job geometry, position and per-address running sums.
  int m_w, m_c, m_pix, m_ch;
  int acc [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Monitor: every BRAM write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) done_cnt++;
      if (wr_en) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", wr_addr, wr_data);
        end else begin
          e = q.pop_front();
          check("wr_addr", int'(wr_addr), e.addr);
          check("wr_data", int'(wr_data), e.data);
          check("done", int'(done), e.last);
          check("latency", cyc - e.cyc, 2);
        end
      end else if (done) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_without_write: got done=1 wr_en=0, expected done=0");
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Present one input and queue the write the model expects 2 cycles later.
  task automatic send(input int d);
    exp_t e;
    int   ow;
    @(posedge clk);
    #1;
    check("pix_cnt", int'(pix_cnt), m_pix);
    check("channel_cnt", int'(channel_cnt), m_ch);
    in_valid = 1'b1;
    in_data  = 16'(d);
    #1;
    check("rd_en", int'(rd_en), 1);
    check("rd_addr", int'(rd_addr), m_pix);
    ow = m_w - 2;
    if (m_ch == 0) acc[m_pix] = sat(d);
    else           acc[m_pix] = sat(acc[m_pix] + d);
    e.addr = m_pix;
    e.data = acc[m_pix];
    e.last = (m_pix == ow * ow - 1 && m_ch == m_c - 1) ? 1 : 0;
    e.cyc  = cyc;
    q.push_back(e);
    if (m_pix == ow * ow - 1) begin
      m_pix = 0;
      m_ch  = (m_ch == m_c - 1) ? 0 : m_ch + 1;
    end else begin
      m_pix++;
    end
  endtask

  // Wait (bounded) for all queued writes to appear.
  task automatic drain();
    int k = 0;
    idle(1);
    while (q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d writes outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic setup(input int w, input int c);
    drain();
    width    = 12'(w);
    channel  = 12'(c);
    m_w      = w;
    m_c      = c;
    m_pix    = 0;
    m_ch     = 0;
    done_cnt = 0;
  endtask

  // Feed a whole list of inputs with 0..max_bubble idle cycles between them.
  task automatic feed(input int d[$], input int max_bubble);
    foreach (d[i]) begin
      send(d[i]);
      if (max_bubble > 0) idle($urandom_range(max_bubble, 0));
    end
  endtask

  initial begin
    int d[$];
    int w, c, n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    width    = 12'd4;
    channel  = 12'd1;
    #1;
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_done", int'(done), 0);
    check("reset_pix_cnt", int'(pix_cnt), 0);
    check("reset_channel_cnt", int'(channel_cnt), 0);
    check("reset_rd_en", int'(rd_en), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // T1: direct writes, two jobs back to back so the second starts on the wrap edge.
    setup(4, 1);
    d = '{1, 2, 3, 4, 5, 6, 7, 8};
    feed(d, 0);
    drain();
    check("t1_done_count", done_cnt, 2);

    // T2: three-channel accumulation through the BRAM.
    setup(4, 3);
    d = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
    feed(d, 0);
    drain();
    for (int a = 0; a < 4; a++) check("t2_mem", int'(mem[a]), 30);
    check("t2_done_count", done_cnt, 1);

    // T3: single-pixel map, every write hits address 0.
    setup(3, 4);
    d = '{1, 2, 3, 4};
    feed(d, 0);
    drain();

    // T4: saturation at both ends, second job starting right after the first.
    setup(3, 2);
    d = '{30000, 10000, -30000, -10000};
    feed(d, 0);
    drain();

    // T5: T2 with random bubbles.
    setup(4, 3);
    d = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
    feed(d, 3);
    drain();
    for (int a = 0; a < 4; a++) check("t5_mem", int'(mem[a]), 30);
    check("t5_done_count", done_cnt, 1);

    // Random jobs: small maps, full-range data, occasional bubbles.
    for (int j = 0; j < 6; j++) begin
      w = (j == 0) ? 3 : $urandom_range(7, 3);
      c = (j == 0) ? 6 : $urandom_range(3, 1);
      setup(w, c);
      d.delete();
      n = (w - 2) * (w - 2) * c;
      for (int i = 0; i < n; i++) d.push_back($signed(16'($urandom)));
      feed(d, (j % 2) * 2);
      drain();
      check("rand_done_count", done_cnt, 1);
    end

    // T6: asynchronous reset mid-pass at channel_cnt=1, pix_cnt=2.
    setup(4, 3);
    d = '{5, 6, 7, 8, 9, 11};
    feed(d, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1;
    check("t6_pre_pix_cnt", int'(pix_cnt), 2);
    check("t6_pre_channel_cnt", int'(channel_cnt), 1);
    #1 rst = 1'b1;
    #1;
    check("t6_wr_en", int'(wr_en), 0);
    check("t6_done", int'(done), 0);
    check("t6_pix_cnt", int'(pix_cnt), 0);
    check("t6_channel_cnt", int'(channel_cnt), 0);
    q.delete();
    m_pix = 0;
    m_ch  = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    done_cnt = 0;
    d = '{7, 1, 2, 3, 4, 4, 4, 4, 9, 9, 9, 9};
    feed(d, 0);
    drain();
    check("t6_done_count", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
